// File: rtl/mfp_ahb_uart_tx.sv
// AHB-Lite slave UART transmitter: 8-entry byte FIFO, programmable divisor, 8N1 frames.
// Define MFP_UART_TX_PARITY_EN to insert an even-parity bit (8E1, 11-bit frame).
module mfp_ahb_uart_tx #(
    parameter int FIFO_DEPTH = 8,
    parameter int DIV_RESET  = 434
) (
    input  logic        HCLK,
    input  logic        HRESETn,
    input  logic        HSEL,
    input  logic [31:0] HADDR,
    input  logic [1:0]  HTRANS,
    input  logic        HWRITE,
    input  logic [2:0]  HSIZE,
    input  logic [31:0] HWDATA,
    output logic [31:0] HRDATA,
    output logic        HREADY,
    output logic        HRESP,
    output logic        UART_TX,
    output logic        UART_TX_IRQ
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

`ifdef MFP_UART_TX_PARITY_EN
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
`else
    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
`endif

    logic            dp_valid_q;
    logic            dp_write_q;
    logic [1:0]      dp_off_q;
    logic [7:0]      mem_q [FIFO_DEPTH];
    logic [AW-1:0]   wptr_q;
    logic [AW-1:0]   rptr_q;
    logic [CW-1:0]   count_q;
    logic [CW-1:0]   count_d;
    logic            ovf_q;
    logic [15:0]     div_q;
    state_t          state_q;
    logic            tx_q;
    logic [7:0]      shift_q;
    logic [2:0]      bitcnt_q;
    logic [15:0]     baud_q;
`ifdef MFP_UART_TX_PARITY_EN
    logic            par_q;
`endif

    logic            wr_data;
    logic            wr_status;
    logic            wr_div;
    logic            fifo_empty;
    logic            fifo_full;
    logic            busy;
    logic            bit_end;
    logic            pop;
    logic            push_ok;
    logic [15:0]     period;
    logic [7:0]      head;
    logic [31:0]     status;
    logic [31:0]     rdata;
    logic            unused_bits;

    assign unused_bits = ^{HSIZE, HADDR[31:4], HADDR[1:0], HWDATA[31:16]};

    assign wr_data    = dp_valid_q & dp_write_q & (dp_off_q == 2'd0);
    assign wr_status  = dp_valid_q & dp_write_q & (dp_off_q == 2'd1);
    assign wr_div     = dp_valid_q & dp_write_q & (dp_off_q == 2'd2);
    assign fifo_empty = (count_q == '0);
    assign fifo_full  = (count_q == FULL_CNT);
    assign busy       = (state_q != S_IDLE);
    assign period     = (div_q < 16'd2) ? 16'd2 : div_q;
    assign bit_end    = (baud_q == 16'd0);
    assign head       = mem_q[rptr_q];

    // The shifter reloads from the FIFO either when idle or right at the end of a stop bit.
    assign pop = ~fifo_empty &
                 ((state_q == S_IDLE) | ((state_q == S_STOP) & bit_end));
    assign push_ok = wr_data & (~fifo_full | pop);

    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            dp_valid_q <= 1'b0;
            dp_write_q <= 1'b0;
            dp_off_q   <= 2'd0;
        end else begin
            dp_valid_q <= HSEL & HTRANS[1];
            dp_write_q <= HWRITE;
            dp_off_q   <= HADDR[3:2];
        end
    end

    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            ovf_q <= 1'b0;
            div_q <= 16'(DIV_RESET);
        end else begin
            if (wr_div)
                div_q <= HWDATA[15:0];
            if (wr_data & ~push_ok)
                ovf_q <= 1'b1;
            else if (wr_status & HWDATA[3])
                ovf_q <= 1'b0;
        end
    end

    always_ff @(posedge HCLK) begin
        if (push_ok)
            mem_q[wptr_q] <= HWDATA[7:0];
    end

    always_comb begin
        count_d = count_q;
        if (push_ok & ~pop)
            count_d = count_q + CW'(1);
        else if (pop & ~push_ok)
            count_d = count_q - CW'(1);
    end

    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (push_ok)
                wptr_q <= wptr_q + AW'(1);
            if (pop)
                rptr_q <= rptr_q + AW'(1);
            count_q <= count_d;
        end
    end

    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            state_q  <= S_IDLE;
            tx_q     <= 1'b1;
            shift_q  <= 8'd0;
            bitcnt_q <= 3'd0;
            baud_q   <= 16'd0;
`ifdef MFP_UART_TX_PARITY_EN
            par_q    <= 1'b0;
`endif
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (pop) begin
                        state_q <= S_START;
                        tx_q    <= 1'b0;
                        shift_q <= head;
                        baud_q  <= period - 16'd1;
`ifdef MFP_UART_TX_PARITY_EN
                        par_q   <= ^head;
`endif
                    end
                end
                S_START: begin
                    if (bit_end) begin
                        state_q  <= S_DATA;
                        tx_q     <= shift_q[0];
                        shift_q  <= {1'b0, shift_q[7:1]};
                        bitcnt_q <= 3'd0;
                        baud_q   <= period - 16'd1;
                    end else begin
                        baud_q <= baud_q - 16'd1;
                    end
                end
                S_DATA: begin
                    if (bit_end) begin
                        baud_q <= period - 16'd1;
                        if (bitcnt_q == 3'd7) begin
`ifdef MFP_UART_TX_PARITY_EN
                            state_q <= S_PARITY;
                            tx_q    <= par_q;
`else
                            state_q <= S_STOP;
                            tx_q    <= 1'b1;
`endif
                        end else begin
                            tx_q     <= shift_q[0];
                            shift_q  <= {1'b0, shift_q[7:1]};
                            bitcnt_q <= bitcnt_q + 3'd1;
                        end
                    end else begin
                        baud_q <= baud_q - 16'd1;
                    end
                end
`ifdef MFP_UART_TX_PARITY_EN
                S_PARITY: begin
                    if (bit_end) begin
                        state_q <= S_STOP;
                        tx_q    <= 1'b1;
                        baud_q  <= period - 16'd1;
                    end else begin
                        baud_q <= baud_q - 16'd1;
                    end
                end
`endif
                S_STOP: begin
                    if (bit_end) begin
                        if (pop) begin
                            state_q <= S_START;
                            tx_q    <= 1'b0;
                            shift_q <= head;
                            baud_q  <= period - 16'd1;
`ifdef MFP_UART_TX_PARITY_EN
                            par_q   <= ^head;
`endif
                        end else begin
                            state_q <= S_IDLE;
                        end
                    end else begin
                        baud_q <= baud_q - 16'd1;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    tx_q    <= 1'b1;
                end
            endcase
        end
    end

    assign status = {16'd0, 8'(count_q), 4'd0, ovf_q, busy, fifo_empty, fifo_full};

    always_comb begin
        rdata = 32'd0;
        if (dp_valid_q & ~dp_write_q) begin
            case (dp_off_q)
                2'd1:    rdata = status;
                2'd2:    rdata = {16'd0, div_q};
                default: rdata = 32'd0;
            endcase
        end
    end

    assign HRDATA      = rdata;
    assign HREADY      = 1'b1;
    assign HRESP       = 1'b0;
    assign UART_TX     = tx_q;
    assign UART_TX_IRQ = fifo_empty & ~busy;

endmodule

// File: tb/tb_mfp_ahb_uart_tx.sv
// Scoreboard bench for mfp_ahb_uart_tx: queued expected frames and register reads
// are checked by free-running line and bus monitors.
module tb_mfp_ahb_uart_tx;

    logic        HCLK = 1'b0;
    logic        HRESETn;
    logic        HSEL;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic        HWRITE;
    logic [2:0]  HSIZE;
    logic [31:0] HWDATA;
    logic [31:0] HRDATA;
    logic        HREADY;
    logic        HRESP;
    logic        UART_TX;
    logic        UART_TX_IRQ;

`ifdef MFP_UART_TX_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif

    typedef struct packed {
        logic [7:0] data;
        int         per_a;
        int         per_b;
        int         split;
        bit         b2b;
        bit         irq;
        bit         trunc;
    } frame_t;

    int          n_vec = 0;
    int          n_fail = 0;
    frame_t      exp_q[$];
    logic [31:0] rd_q[$];
    string       rd_nm[$];
    bit          in_frame = 0;
    logic        rd_dp = 1'b0;

    mfp_ahb_uart_tx dut (
        .HCLK        (HCLK),
        .HRESETn     (HRESETn),
        .HSEL        (HSEL),
        .HADDR       (HADDR),
        .HTRANS      (HTRANS),
        .HWRITE      (HWRITE),
        .HSIZE       (HSIZE),
        .HWDATA      (HWDATA),
        .HRDATA      (HRDATA),
        .HREADY      (HREADY),
        .HRESP       (HRESP),
        .UART_TX     (UART_TX),
        .UART_TX_IRQ (UART_TX_IRQ)
    );

    always #5 HCLK = ~HCLK;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic lvl(input frame_t f, input int k);
        if (k == 0)
            return 1'b0;
        if (k <= 8)
            return f.data[k-1];
`ifdef MFP_UART_TX_PARITY_EN
        if (k == 9)
            return ^f.data;
`endif
        return 1'b1;
    endfunction

    task automatic push_frame(input logic [7:0] d, input int pa, input int pb,
                              input int sp, input bit b2b, input bit irq, input bit tr);
        frame_t f;
        f.data  = d;
        f.per_a = pa;
        f.per_b = pb;
        f.split = sp;
        f.b2b   = b2b;
        f.irq   = irq;
        f.trunc = tr;
        exp_q.push_back(f);
    endtask

    task automatic ahb_write(input logic [31:0] a, input logic [31:0] d);
        HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b1; HADDR = a;
        @(posedge HCLK); #1;
        HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0; HADDR = 32'd0; HWDATA = d;
        @(posedge HCLK); #1;
    endtask

    task automatic ahb_read(input logic [31:0] a, input logic [31:0] e, input string nm);
        rd_q.push_back(e);
        rd_nm.push_back(nm);
        HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b0; HADDR = a;
        @(posedge HCLK); #1;
        HSEL = 1'b0; HTRANS = 2'b00; HADDR = 32'd0;
        @(posedge HCLK); #1;
    endtask

    task automatic wait_drain(input int limit, input string nm);
        for (int i = 0; i < limit; i++) begin
            @(posedge HCLK);
            if (exp_q.size() == 0 && !in_frame) begin
                #1;
                return;
            end
        end
        n_vec++;
        n_fail++;
        $display("FAIL %s: %0d frames pending after %0d cycles, expected 0",
                 nm, exp_q.size(), limit);
        exp_q.delete();
        #1;
    endtask

    // Bus monitor: a read's data phase follows its registered address phase.
    initial begin : rd_addr_mon
        forever begin
            @(posedge HCLK);
            rd_dp <= HRESETn && HSEL && HTRANS[1] && !HWRITE;
        end
    end

    initial begin : rd_data_mon
        forever begin
            @(negedge HCLK);
            if (rd_dp) begin
                if (rd_q.size() == 0) begin
                    n_vec++;
                    n_fail++;
                    $display("FAIL unexpected_read: got %h expected no read", HRDATA);
                end else begin
                    chk(rd_nm.pop_front(), HRDATA, rd_q.pop_front());
                end
            end
        end
    end

    // Line monitor: decodes each frame cycle by cycle against the queued expectation.
    initial begin : uart_mon
        frame_t e;
        bit     have_start;
        bit     ok;
        bit     aborted;
        int     nper;
        int     bad_c;
        logic   bad_v;
        have_start = 0;
        forever begin
            if (!have_start) begin
                @(negedge HCLK);
                if (!(HRESETn === 1'b1 && UART_TX === 1'b0))
                    continue;
            end
            have_start = 0;
            if (exp_q.size() == 0) begin
                n_vec++;
                n_fail++;
                $display("FAIL unexpected_frame: line 0 with no frame queued, expected 1");
                while (UART_TX !== 1'b1)
                    @(negedge HCLK);
                continue;
            end
            e = exp_q.pop_front();
            in_frame = 1;
            aborted = 0;
            for (int k = 0; k < NB && !aborted; k++) begin
                ok = 1;
                bad_c = 0;
                bad_v = 1'b0;
                nper = (k < e.split) ? e.per_a : e.per_b;
                for (int c = 0; c < nper; c++) begin
                    if (k != 0 || c != 0)
                        @(negedge HCLK);
                    if (HRESETn !== 1'b1) begin
                        aborted = 1;
                        break;
                    end
                    if (ok && UART_TX !== lvl(e, k)) begin
                        ok = 0;
                        bad_c = c;
                        bad_v = UART_TX;
                    end
                end
                if (!aborted) begin
                    n_vec++;
                    if (!ok) begin
                        n_fail++;
                        $display("FAIL frame_%h_bit%0d: line %b at cycle %0d, expected %b for %0d cycles",
                                 e.data, k, bad_v, bad_c, lvl(e, k), nper);
                    end
                end
            end
            if (aborted) begin
                chk("frame_truncated", 32'd1, {31'd0, e.trunc});
                in_frame = 0;
                continue;
            end
            if (e.trunc) begin
                n_vec++;
                n_fail++;
                $display("FAIL frame_%h_trunc: frame completed, expected truncation", e.data);
            end
            @(negedge HCLK);
            if (e.b2b) begin
                chk("b2b_start", {31'd0, UART_TX}, 32'd0);
                if (UART_TX === 1'b0 && HRESETn === 1'b1)
                    have_start = 1;
            end else begin
                chk("idle_after_stop", {31'd0, UART_TX}, 32'd1);
                if (e.irq)
                    chk("irq_after_frame", {31'd0, UART_TX_IRQ}, 32'd1);
            end
            in_frame = 0;
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        HRESETn = 1'b0; HSEL = 1'b0; HADDR = 32'd0; HTRANS = 2'b00;
        HWRITE = 1'b0; HSIZE = 3'b010; HWDATA = 32'd0;
        repeat (3) @(posedge HCLK);
        #1;
        chk("rst_tx", {31'd0, UART_TX}, 32'd1);
        chk("rst_irq", {31'd0, UART_TX_IRQ}, 32'd1);
        chk("rst_hrdata", HRDATA, 32'd0);
        chk("hready", {31'd0, HREADY}, 32'd1);
        chk("hresp", {31'd0, HRESP}, 32'd0);
        HRESETn = 1'b1;
        @(posedge HCLK); #1;

        ahb_read(32'h4, 32'h0000_0002, "rst_status");
        ahb_read(32'h8, 32'd434, "rst_divisor");
        ahb_read(32'h0, 32'd0, "data_read");
        ahb_write(32'hC, 32'hFFFF_FFFF);
        ahb_read(32'hC, 32'd0, "reserved_read");
        ahb_read(32'h4, 32'h0000_0002, "status_after_rsvd_wr");

        // 0x55 at 4-cycle bits
        ahb_write(32'h8, 32'd4);
        ahb_read(32'h8, 32'd4, "div_rd4");
        push_frame(8'h55, 4, 4, NB, 0, 1, 0);
        ahb_write(32'h0, 32'h55);
        ahb_read(32'h4, 32'h0000_0006, "status_busy");
        wait_drain(200, "frame_55");
        chk("irq_idle", {31'd0, UART_TX_IRQ}, 32'd1);
        ahb_read(32'h4, 32'h0000_0002, "status_idle");

        // divisor 0 clamps to 2-cycle bits
        ahb_write(32'h8, 32'd0);
        ahb_read(32'h8, 32'd0, "div_rd0");
        push_frame(8'hA3, 2, 2, NB, 0, 1, 0);
        ahb_write(32'h0, 32'hA3);
        wait_drain(100, "frame_a3_div0");

        // back-to-back frames
        ahb_write(32'h8, 32'd3);
        push_frame(8'hA5, 3, 3, NB, 1, 0, 0);
        push_frame(8'h3C, 3, 3, NB, 0, 1, 0);
        ahb_write(32'h0, 32'hA5);
        ahb_write(32'h0, 32'h3C);
        wait_drain(200, "frames_a5_3c");

        // divisor 8 -> 16 written during data bit 3
        ahb_write(32'h8, 32'd8);
        push_frame(8'h96, 8, 16, 5, 0, 1, 0);
        ahb_write(32'h0, 32'h96);
        repeat (35) @(posedge HCLK);
        #1;
        ahb_write(32'h8, 32'd16);
        wait_drain(400, "frame_96_divchg");

        // FIFO fill and overflow
        ahb_write(32'h8, 32'd40);
        for (int i = 1; i <= 9; i++) begin
            push_frame(8'(i), 40, 40, NB, (i < 9), (i == 9), 0);
            ahb_write(32'h0, 32'(i));
        end
        ahb_read(32'h4, 32'h0000_0805, "status_full");
        ahb_write(32'h0, 32'h0A);
        ahb_read(32'h4, 32'h0000_080D, "status_ovf");
        ahb_write(32'h4, 32'h8);
        ahb_read(32'h4, 32'h0000_0805, "status_ovf_clr");
        wait_drain(5000, "frames_fifo");

        // reset during data bit 5, with a DATA write in its data phase
        ahb_write(32'h8, 32'd8);
        push_frame(8'h5A, 8, 8, NB, 0, 0, 1);
        ahb_write(32'h0, 32'h5A);
        repeat (50) @(posedge HCLK);
        #1;
        HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b1; HADDR = 32'h0;
        @(posedge HCLK); #1;
        HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0; HWDATA = 32'hEE;
        HRESETn = 1'b0;
        @(posedge HCLK); #1;
        chk("midrst_tx", {31'd0, UART_TX}, 32'd1);
        chk("midrst_irq", {31'd0, UART_TX_IRQ}, 32'd1);
        chk("midrst_hrdata", HRDATA, 32'd0);
        repeat (2) @(posedge HCLK);
        #1;
        HRESETn = 1'b1;
        @(posedge HCLK); #1;
        ahb_read(32'h4, 32'h0000_0002, "status_after_rst");
        ahb_read(32'h8, 32'd434, "div_after_rst");
        repeat (30) @(posedge HCLK);
        #1;

        // 0x07 then 0x03 (parity 1 and 0 when parity is built in)
        ahb_write(32'h8, 32'd4);
        push_frame(8'h07, 4, 4, NB, 1, 0, 0);
        push_frame(8'h03, 4, 4, NB, 0, 1, 0);
        ahb_write(32'h0, 32'h07);
        ahb_write(32'h0, 32'h03);
        wait_drain(300, "frames_07_03");

        repeat (20) @(posedge HCLK);
        #1;
        if (rd_q.size() != 0) begin
            n_vec++;
            n_fail++;
            $display("FAIL reads_pending: %0d reads unchecked, expected 0", rd_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
